// File: rtl/frame_readout.sv
// Frame readout: streams one frame from the highlight/image buffers,
// composites each pixel into a small output FIFO and clears the highlight.
module frame_readout #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int IMAGE_SIZE = 921600,
    parameter int AW         = $clog2(IMAGE_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [23:0]   highlight_dout,
    input  logic [23:0]   image_dout,
    output logic          clr_wr_en,
    output logic [AW-1:0] clr_addr,
    input  logic          out_full,
    output logic          out_wr_en,
    output logic [23:0]   out_din
);

    generate
        if (WIDTH * HEIGHT != IMAGE_SIZE || IMAGE_SIZE < 2) begin : g_bad_size
            $error("frame_readout: IMAGE_SIZE must equal WIDTH*HEIGHT and be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] PENULT = AW'(IMAGE_SIZE - 2);

    state_t      state;
    state_t      state_n;
    logic        first_rd;
    logic        next_rd;
    logic        push;
    logic        pop;
    logic        room;
    logic [2:0]  occ;
    logic [1:0]  cnt;
    logic        wp;
    logic        rp;
    logic [23:0] buf_q [0:1];
    logic [23:0] pixel;

    // Data arrives in the rd_en cycle and is captured at its closing edge.
    assign push      = rd_en;
    assign pop       = out_wr_en;
    assign pixel     = (highlight_dout != 24'd0) ? highlight_dout : image_dout;
    assign out_wr_en = (cnt != 2'd0) && !out_full;
    assign out_din   = (cnt != 2'd0) ? buf_q[rp] : 24'd0;
    assign clr_wr_en = rd_en;
    assign clr_addr  = rd_en ? rd_addr : '0;

    // Buffered + in-flight - leaving must stay below 2 before a new issue.
    assign occ  = {1'b0, cnt} + {2'b00, rd_en} - {2'b00, pop};
    assign room = occ < 3'd2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        first_rd = 1'b0;
        next_rd  = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = READ;
                    first_rd = 1'b1;
                end
            end
            READ: begin
                if (room) begin
                    next_rd = 1'b1;
                    if (rd_addr == PENULT) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt == 2'd0 && !rd_en) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            cnt      <= 2'd0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            buf_q[0] <= 24'd0;
            buf_q[1] <= 24'd0;
        end else begin
            rd_en <= first_rd || next_rd;
            if (first_rd) begin
                rd_addr <= '0;
            end else if (next_rd) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (push) begin
                buf_q[wp] <= pixel;
                wp        <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
